pong_game_sequencer: RTL and testbench
======================================

# pong_game_sequencer

Game-flow controller for the VGA pong datapath. Debounces the player buttons and runs the IDLE/SERVE/PLAY/PAUSE/OVER state machine. Generates the movement tick that steps the ball and paddle, and keeps score and lives. It sits between `KEY` and the ball/paddle/collision logic, replacing ad-hoc start/over flags with one sequenced source of truth.

## Interface
- `TICK_DIV`, 262144: `CLOCK_50` cycles per movement tick at speed level 0; power of two, ≥ 16.
- `DEBOUNCE_CYCLES`, 500000: cycles a synchronized key must be stable before its debounced value changes.
- `BOOST_DIV`, 4194304: cycles between paddle-step increments while one direction is held.
- `SERVE_TICKS`, 60: ticks spent in SERVE before PLAY.
- `OVER_HOLD_TICKS`, 120: ticks spent in OVER before IDLE.
- `LIVES`, 3: lives loaded at game start; 1..3.
- `CLOCK_50` in 1: sole clock.
- `RESET` in 1: asynchronous, active-high reset.
- `KEY` in 4: raw active-low buttons. [0] right, [1] left, [3] start/pause; [2] unused.
- `ball_lost` in 1: one-cycle pulse from the datapath when the ball passes below the paddle row.
- `paddle_hit` in 1: one-cycle pulse from the datapath on a ball/paddle collision.
- `state` out 3: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4.
- `move_tick` out 1: one-cycle pulse; ball and paddle advance one step.
- `reset_objects` out 1: high means the datapath holds the ball at (310,456) and the paddle at 255.
- `show_pause` out 1: enables the PAUSE banner.
- `game_over` out 1: high in OVER.
- `paddle_dir` out 2: {left,right}; 00 when neither or both keys are held.
- `paddle_step` out 5: paddle pixels per tick, 1..31.
- `score` out 8: two BCD digits, {tens,units}.
- `lives` out 2: remaining lives.

## Operation
- **Input conditioning.**
  - `KEY[0]`, `KEY[1]` and `KEY[3]` each pass through a 2-FF synchronizer, then a debounce counter.
  - Debounced value updates only after `DEBOUNCE_CYCLES` consecutive equal synchronized samples.
  - A start press is the debounced `KEY[3]` 1→0 edge: one pulse per physical press, however long the key is held.
- **Tick generator.**
  - Free-running counter; `tick_raw` fires when the count reaches `period-1`, then the counter wraps to 0.
  - `period = TICK_DIV >> speed_level` (see Configuration).
  - `move_tick = tick_raw` only while in PLAY. SERVE and OVER count `tick_raw`.
- **FSM transitions.**
  - IDLE, on start press: load `lives=LIVES`, clear `score` → SERVE.
  - SERVE, after `SERVE_TICKS` ticks → PLAY.
  - PLAY, on `ball_lost`: `lives-1`. If the result is 0 → OVER, else → SERVE.
  - PLAY, on start press → PAUSE.
  - PAUSE, on start press → PLAY. The tick counter keeps running; the first tick after resume fires at whatever phase the counter is at.
  - OVER, after `OVER_HOLD_TICKS` ticks → IDLE. `score` is retained for display.
- **Decoded outputs.**
  - `reset_objects` = IDLE | SERVE | OVER.
  - `show_pause` = IDLE | PAUSE.
  - `game_over` = OVER.
- **Simultaneous events.**
  - `ball_lost` outranks a start press and `paddle_hit` in the same cycle; both of those are dropped.
  - `ball_lost`/`paddle_hit` outside PLAY are ignored.
- **Score.** `paddle_hit` in PLAY does a BCD +1: units 9→0 carries into tens; 99→00 wraps.
- **Boost.**
  - Free-running `BOOST_DIV` counter.
  - On its wrap, `paddle_step` increments if in PLAY and exactly one direction is held, saturating at 31.
  - `paddle_step` returns to 1 immediately when the held-key condition or PLAY ends.
- **Reset.** `RESET` mid-game aborts to IDLE at once; no other state is preserved.

## Timing
- All outputs registered.
- `state` changes on the clock edge after the qualifying event; `reset_objects`, `show_pause`, `game_over` follow in the same cycle as `state`.
- `move_tick` is high exactly one cycle per period. `score`/`lives` update one cycle after the input pulse.
- Key-to-effect latency: 2 synchronizer cycles + `DEBOUNCE_CYCLES` + 1 cycle.
- Reset values: `state`=0, `move_tick`=0, `reset_objects`=1, `show_pause`=1, `game_over`=0, `paddle_dir`=00, `paddle_step`=1, `score`=0x00, `lives`=`LIVES`, all counters 0, debounced keys=1 (released).

## Configuration
- `PONG_SPEEDUP_EN` defined:
  - `speed_level = min(score[7:4], 3)`, so the ball speeds up every 10 points, up to 8x.
  - A level change takes effect at the next counter wrap. The counter also wraps immediately if it already exceeds the new `period-1`.
- Undefined: `speed_level` is constant 0 and the period is always `TICK_DIV`.

## Test plan
All scenarios use `TICK_DIV=16`, `DEBOUNCE_CYCLES=4`, `SERVE_TICKS=2`, `OVER_HOLD_TICKS=3`, `BOOST_DIV=8`, `LIVES=3`.
- Reset, then one start press held 50 cycles → exactly one IDLE→SERVE; PLAY after 2 ticks; `move_tick` every 16 cycles in PLAY only.
- Glitch: 3-cycle `KEY[3]` low pulse → no state change. 10-cycle press in PLAY → PAUSE, `show_pause`=1, no `move_tick`; second press → PLAY.
- Three `ball_lost` pulses in PLAY → `lives` 2, 1, then OVER with `lives`=0, `game_over`=1; IDLE after 3 ticks with `score` retained.
- 100 `paddle_hit` pulses → `score` 0x09→0x10 carry, ends at 0x00. `ball_lost`+`paddle_hit` in the same cycle → score unchanged, lives−1.
- `KEY[0]` held in PLAY → `paddle_dir`=01, `paddle_step` 1→31 then saturates. `KEY[1]` added → `paddle_dir`=00, `paddle_step`=1.
- With `PONG_SPEEDUP_EN`: `score` reaching 0x10 → `move_tick` period 8; at 0x30 and above → period 2. `RESET` asserted mid-PLAY → all reset values, asynchronously.

Source files
------------

// File: rtl/pong_game_sequencer.sv
// pong_game_sequencer: key debounce, IDLE/SERVE/PLAY/PAUSE/OVER game FSM, movement tick, score/lives, paddle boost.
// Optional PONG_SPEEDUP_EN: tick period shrinks with score tens digit (up to 8x).
module pong_game_sequencer #(
  parameter int TICK_DIV        = 262144,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BOOST_DIV       = 4194304,
  parameter int SERVE_TICKS     = 60,
  parameter int OVER_HOLD_TICKS = 120,
  parameter int LIVES           = 3
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [3:0] KEY,
  input  logic       ball_lost,
  input  logic       paddle_hit,
  output logic [2:0] state,
  output logic       move_tick,
  output logic       reset_objects,
  output logic       show_pause,
  output logic       game_over,
  output logic [1:0] paddle_dir,
  output logic [4:0] paddle_step,
  output logic [7:0] score,
  output logic [1:0] lives
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(BOOST_DIV + 1);
  localparam int HW = $clog2(SERVE_TICKS + OVER_HOLD_TICKS + 1);
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, PAUSE, OVER} state_t;
  state_t st, nxt;
  logic [2:0] raw, s1, s2, deb, deb_upd;
  logic [DW-1:0] dcnt [3];
  logic [TW-1:0] tcnt, plast;
  logic [BW-1:0] bcnt;
  logic [HW-1:0] hcnt;
  logic [1:0] lvl;
  logic start_press, tick_raw, left, right, hold, hit, bwrap;
  logic [7:0] score_inc;
  assign raw = {KEY[3], KEY[1], KEY[0]};
  always_comb begin
    deb_upd = '0;
    for (int k = 0; k < 3; k++) deb_upd[k] = s2[k] != deb[k] && dcnt[k] == DW'(DEBOUNCE_CYCLES - 1);
  end
  always_ff @(posedge CLOCK_50 or posedge RESET)
    if (RESET) begin
      s1 <= '1;
      s2 <= '1;
      deb <= '1;
      for (int k = 0; k < 3; k++) dcnt[k] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int k = 0; k < 3; k++) begin
        dcnt[k] <= (s2[k] == deb[k] || deb_upd[k]) ? '0 : dcnt[k] + 1'b1;
        if (deb_upd[k]) deb[k] <= s2[k];
      end
    end
  // a start press is the debounced release->press edge, so holding the key never repeats it
  assign start_press = deb_upd[2] & deb[2];
  assign left = ~deb[1];
  assign right = ~deb[0];
  assign hold = st == PLAY && (left ^ right);
  assign hit = st == PLAY && paddle_hit && !ball_lost;
  assign bwrap = bcnt == BW'(BOOST_DIV - 1);
`ifdef PONG_SPEEDUP_EN
  assign lvl = score[7:4] > 4'd3 ? 2'd3 : score[5:4];
`else
  assign lvl = 2'd0;
`endif
  assign plast = TW'((TICK_DIV >> lvl) - 1);
  // >= lets a shortened period wrap at once when the count is already past it
  assign tick_raw = tcnt >= plast;
  assign score_inc = score[3:0] == 4'd9 ? {score[7:4] == 4'd9 ? 4'd0 : score[7:4] + 4'd1, 4'd0}
                                        : {score[7:4], score[3:0] + 4'd1};
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    if (start_press) nxt = SERVE;
      SERVE:   if (tick_raw && hcnt == HW'(SERVE_TICKS - 1)) nxt = PLAY;
      PLAY:    if (ball_lost) nxt = lives == 2'd1 ? OVER : SERVE;
               else if (start_press) nxt = PAUSE;
      PAUSE:   if (start_press) nxt = PLAY;
      OVER:    if (tick_raw && hcnt == HW'(OVER_HOLD_TICKS - 1)) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50 or posedge RESET)
    if (RESET) begin
      st <= IDLE;
      tcnt <= '0;
      bcnt <= '0;
      hcnt <= '0;
      move_tick <= 1'b0;
      reset_objects <= 1'b1;
      show_pause <= 1'b1;
      game_over <= 1'b0;
      paddle_dir <= 2'b00;
      paddle_step <= 5'd1;
      score <= 8'h00;
      lives <= 2'(LIVES);
    end else begin
      st <= nxt;
      tcnt <= tick_raw ? '0 : tcnt + 1'b1;
      bcnt <= bwrap ? '0 : bcnt + 1'b1;
      hcnt <= nxt != st ? '0 : tick_raw ? hcnt + 1'b1 : hcnt;
      move_tick <= tick_raw && st == PLAY && nxt == PLAY;
      reset_objects <= nxt == IDLE || nxt == SERVE || nxt == OVER;
      show_pause <= nxt == IDLE || nxt == PAUSE;
      game_over <= nxt == OVER;
      paddle_dir <= left ^ right ? {left, right} : 2'b00;
      paddle_step <= !hold ? 5'd1 : bwrap && paddle_step != 5'd31 ? paddle_step + 5'd1 : paddle_step;
      if (st == IDLE && start_press) begin
        score <= 8'h00;
        lives <= 2'(LIVES);
      end else begin
        if (hit) score <= score_inc;
        if (st == PLAY && ball_lost) lives <= lives - 2'd1;
      end
    end
  assign state = st;
endmodule

// File: tb/tb_pong_game_sequencer.sv
// tb_pong_game_sequencer: randomized scenario bench with a score/lives/period reference model.
module tb_pong_game_sequencer;
  logic CLOCK_50 = 1'b0, RESET = 1'b1, ball_lost = 1'b0, paddle_hit = 1'b0;
  logic [3:0] KEY = 4'hF;
  logic [2:0] state;
  logic move_tick, reset_objects, show_pause, game_over;
  logic [1:0] paddle_dir, lives;
  logic [4:0] paddle_step;
  logic [7:0] score;
  int total = 0, bad = 0, sc = 0, lv = 3;
  int n_serve = 0, n_tick = 0, n_badtick = 0;
  logic [2:0] ps = 3'd0;

  pong_game_sequencer #(.TICK_DIV(16), .DEBOUNCE_CYCLES(4), .BOOST_DIV(8), .SERVE_TICKS(2),
                        .OVER_HOLD_TICKS(3), .LIVES(3)) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .KEY(KEY), .ball_lost(ball_lost), .paddle_hit(paddle_hit),
    .state(state), .move_tick(move_tick), .reset_objects(reset_objects), .show_pause(show_pause),
    .game_over(game_over), .paddle_dir(paddle_dir), .paddle_step(paddle_step), .score(score), .lives(lives));

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (ps == 3'd0 && state == 3'd1) n_serve <= n_serve + 1;
    if (move_tick) n_tick <= n_tick + 1;
    if (move_tick && state != 3'd2) n_badtick <= n_badtick + 1;
    ps <= state;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  function automatic int exp_period(input int v);
`ifdef PONG_SPEEDUP_EN
    return 16 >> ((v / 10) > 3 ? 3 : v / 10);
`else
    return 16 + 0 * v;
`endif
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic press(input int n);
    KEY[3] = 1'b0;
    cyc(n);
    KEY[3] = 1'b1;
    cyc(12);
  endtask

  task automatic hit_once();
    paddle_hit = 1'b1;
    cyc(1);
    paddle_hit = 1'b0;
    sc = (sc + 1) % 100;
  endtask

  task automatic lose_once();
    ball_lost = 1'b1;
    cyc(1);
    ball_lost = 1'b0;
    lv = lv - 1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    int c = 0;
    while (state !== s && c < budget) begin
      cyc(1);
      c++;
    end
    total++;
    if (state !== s) begin
      bad++;
      $display("FAIL %s: state=%0d want %0d", nm, state, s);
    end
  endtask

  task automatic measure_period(output int p);
    int c = 0;
    p = -1;
    while (move_tick !== 1'b1 && c < 100) begin
      cyc(1);
      c++;
    end
    if (move_tick !== 1'b1) return;
    c = 0;
    do begin
      cyc(1);
      c++;
    end while (move_tick !== 1'b1 && c < 100);
    if (move_tick === 1'b1) p = c;
  endtask

  task automatic start_game();
    press(20);
    wait_state(3'd2, 100, "start_game_play");
    sc = 0;
    lv = 3;
  endtask

  task automatic test_reset();
    logic [31:0] got [9];
    int want [9] = '{0, 0, 1, 1, 0, 0, 1, 0, 3};
    string nm [9] = '{"rst_state", "rst_move_tick", "rst_reset_objects", "rst_show_pause", "rst_game_over",
                      "rst_paddle_dir", "rst_paddle_step", "rst_score", "rst_lives"};
    RESET = 1'b1;
    cyc(3);
    got = '{32'(state), 32'(move_tick), 32'(reset_objects), 32'(show_pause), 32'(game_over),
            32'(paddle_dir), 32'(paddle_step), 32'(score), 32'(lives)};
    for (int i = 0; i < 9; i++) begin
      total++;
      if (got[i] !== 32'(want[i])) begin
        bad++;
        $display("FAIL %s: got %0d want %0d", nm[i], got[i], want[i]);
      end
    end
    RESET = 1'b0;
    cyc(20);
    total++;
    if (state !== 3'd0) begin
      bad++;
      $display("FAIL idle_hold: state=%0d want 0", state);
    end
  endtask

  task automatic test_start();
    int s0, p, t_serve = -1, t_play = -1;
    s0 = n_serve;
    KEY[3] = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (t_serve < 0 && state == 3'd1) t_serve = i;
      if (t_play < 0 && state == 3'd2) t_play = i;
    end
    KEY[3] = 1'b1;
    cyc(12);
    total++;
    if (n_serve - s0 != 1) begin
      bad++;
      $display("FAIL serve_once: entries=%0d want 1", n_serve - s0);
    end
    total++;
    if (state !== 3'd2) begin
      bad++;
      $display("FAIL held_start_play: state=%0d want 2", state);
    end
    total++;
    if (t_serve < 0 || t_play - t_serve < 17 || t_play - t_serve > 32) begin
      bad++;
      $display("FAIL serve_len: cycles=%0d want 17..32", t_play - t_serve);
    end
    measure_period(p);
    total++;
    if (p != exp_period(sc)) begin
      bad++;
      $display("FAIL play_period: got %0d want %0d", p, exp_period(sc));
    end
  endtask

  task automatic test_pause();
    int t0, p;
    KEY[3] = 1'b0;
    cyc(3);
    KEY[3] = 1'b1;
    cyc(20);
    total++;
    if (state !== 3'd2) begin
      bad++;
      $display("FAIL glitch: state=%0d want 2", state);
    end
    press(10);
    total++;
    if (state !== 3'd3 || show_pause !== 1'b1 || reset_objects !== 1'b0) begin
      bad++;
      $display("FAIL pause: state=%0d show_pause=%0d reset_objects=%0d want 3/1/0", state, show_pause, reset_objects);
    end
    t0 = n_tick;
    cyc(40);
    total++;
    if (n_tick != t0) begin
      bad++;
      $display("FAIL pause_ticks: got %0d want 0", n_tick - t0);
    end
    press(10);
    total++;
    if (state !== 3'd2 || show_pause !== 1'b0) begin
      bad++;
      $display("FAIL resume: state=%0d show_pause=%0d want 2/0", state, show_pause);
    end
    measure_period(p);
    total++;
    if (p != exp_period(sc)) begin
      bad++;
      $display("FAIL resume_period: got %0d want %0d", p, exp_period(sc));
    end
  endtask

  task automatic test_score();
    for (int i = 0; i < 100; i++) begin
      cyc($urandom_range(0, 3));
      hit_once();
      total++;
      if (score !== bcd(sc)) begin
        bad++;
        $display("FAIL score_hit%0d: got %h want %h", i, score, bcd(sc));
      end
    end
    total++;
    if (score !== 8'h00 || state !== 3'd2) begin
      bad++;
      $display("FAIL score_wrap: score=%h state=%0d want 00/2", score, state);
    end
  endtask

  task automatic test_lives();
    int c, p;
    ball_lost = 1'b1;
    paddle_hit = 1'b1;
    cyc(1);
    ball_lost = 1'b0;
    paddle_hit = 1'b0;
    lv = lv - 1;
    total++;
    if (score !== bcd(sc) || lives !== 2'(lv) || state !== 3'd1) begin
      bad++;
      $display("FAIL lost_and_hit: score=%h lives=%0d state=%0d want %h/%0d/1", score, lives, state, bcd(sc), lv);
    end
    for (int r = 0; r < 2; r++) begin
      wait_state(3'd2, 100, "serve_to_play");
      repeat ($urandom_range(1, 12)) begin
        cyc($urandom_range(0, 2));
        hit_once();
      end
      total++;
      if (score !== bcd(sc)) begin
        bad++;
        $display("FAIL score_round%0d: got %h want %h", r, score, bcd(sc));
      end
      lose_once();
      total++;
      if (lives !== 2'(lv) || state !== (lv == 0 ? 3'd4 : 3'd1)) begin
        bad++;
        $display("FAIL lost_round%0d: lives=%0d state=%0d want %0d", r, lives, state, lv);
      end
    end
    total++;
    if (game_over !== 1'b1 || reset_objects !== 1'b1 || show_pause !== 1'b0) begin
      bad++;
      $display("FAIL over_flags: game_over=%0d reset_objects=%0d show_pause=%0d want 1/1/0", game_over, reset_objects, show_pause);
    end
    p = exp_period(sc);
    c = 0;
    while (state === 3'd4 && c < 200) begin
      cyc(1);
      c++;
    end
    total++;
    if (state !== 3'd0 || c < 2 * p || c > 3 * p + 1) begin
      bad++;
      $display("FAIL over_hold: state=%0d cycles=%0d want 0 within %0d..%0d", state, c, 2 * p, 3 * p + 1);
    end
    total++;
    if (score !== bcd(sc) || game_over !== 1'b0) begin
      bad++;
      $display("FAIL score_kept: score=%h game_over=%0d want %h/0", score, game_over, bcd(sc));
    end
  endtask

  task automatic test_boost();
    int dir, viol = 0;
    logic [4:0] prev;
    start_game();
    dir = $urandom_range(0, 1);
    KEY[dir] = 1'b0;
    cyc(10);
    total++;
    if (paddle_dir !== (dir == 0 ? 2'b01 : 2'b10)) begin
      bad++;
      $display("FAIL boost_dir: got %b want %b", paddle_dir, dir == 0 ? 2'b01 : 2'b10);
    end
    prev = paddle_step;
    for (int i = 0; i < 400 && paddle_step !== 5'd31; i++) begin
      cyc(1);
      if (paddle_step < prev) viol++;
      prev = paddle_step;
    end
    total++;
    if (paddle_step !== 5'd31 || viol != 0) begin
      bad++;
      $display("FAIL boost_ramp: step=%0d drops=%0d want 31/0", paddle_step, viol);
    end
    cyc(40);
    total++;
    if (paddle_step !== 5'd31) begin
      bad++;
      $display("FAIL boost_sat: got %0d want 31", paddle_step);
    end
    KEY[1 - dir] = 1'b0;
    cyc(10);
    total++;
    if (paddle_dir !== 2'b00 || paddle_step !== 5'd1) begin
      bad++;
      $display("FAIL boost_both: dir=%b step=%0d want 00/1", paddle_dir, paddle_step);
    end
    KEY = 4'hF;
    cyc(12);
  endtask

  task automatic test_async_reset();
    logic [31:0] got [8];
    int want [8] = '{0, 0, 1, 1, 0, 1, 0, 3};
    string nm [8] = '{"ar_state", "ar_move_tick", "ar_reset_objects", "ar_show_pause", "ar_game_over",
                      "ar_paddle_step", "ar_score", "ar_lives"};
    repeat (3) hit_once();
    lose_once();
    wait_state(3'd2, 100, "ar_play");
    KEY[0] = 1'b0;
    cyc(30);
    @(posedge CLOCK_50);
    #2 RESET = 1'b1;
    #1 got = '{32'(state), 32'(move_tick), 32'(reset_objects), 32'(show_pause), 32'(game_over),
               32'(paddle_step), 32'(score), 32'(lives)};
    for (int i = 0; i < 8; i++) begin
      total++;
      if (got[i] !== 32'(want[i])) begin
        bad++;
        $display("FAIL %s: got %0d want %0d", nm[i], got[i], want[i]);
      end
    end
    KEY = 4'hF;
    cyc(2);
    RESET = 1'b0;
    cyc(5);
  endtask

  task automatic test_speed();
    int p;
    int steps [3] = '{0, 10, 20};
    start_game();
    for (int s = 0; s < 3; s++) begin
      repeat (steps[s]) begin
        cyc($urandom_range(0, 2));
        hit_once();
      end
      measure_period(p);
      measure_period(p);
      total++;
      if (p != exp_period(sc)) begin
        bad++;
        $display("FAIL speed_score%0d: period %0d want %0d", sc, p, exp_period(sc));
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_pause();
    test_score();
    test_lives();
    test_boost();
    test_async_reset();
    test_speed();
    total++;
    if (n_badtick != 0) begin
      bad++;
      $display("FAIL tick_outside_play: got %0d want 0", n_badtick);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
